display_scan_decoder: RTL and testbench
=======================================

Name: display_scan_decoder

Overview:
- Receive-side counterpart of the four-digit multiplexed seven-segment driver.
- Samples the active-low segment, decimal-point and anode lines, waits for them to settle, and works out which digit is lit.
- Inverse-decodes the segment pattern back to the 4-bit code and holds one register per digit.
- Used for on-board self-check and loopback of the display path in the ring-oscillator measurement design; reports stale digits and illegal patterns.

Parameters:
- STABLE_CYCLES, 16: consecutive cycles the synchronized line vector must stay unchanged before capture (min 2).
- TIMEOUT, 524288: cycles without a refresh before a digit's valid bit drops (2x full scan frame of the driver at N=18).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg0..seg6  input  1 each  segment lines a..g, active-low
- dp  input  1  decimal point, active-low; synchronized, ignored for decoding
- an1..an4  input  1 each  anode enables, active-low; an4 = digit 0, an3 = digit 1, an2 = digit 2, an1 = digit 3
- out0..out3  output  4 each  last decoded code per digit
- valid  output  4  bit i set while digit i has been refreshed within TIMEOUT cycles
- upd  output  1  one-cycle pulse when any digit register is written
- upd_digit  output  2  index of the written digit; meaningful only when upd=1
- err_seg  output  1  one-cycle pulse: stable single-anode frame with an undecodable segment pattern
- err_an  output  1  one-cycle pulse: stable frame with two or more anodes low

Behaviour:
- Reset (synchronous, active-high), values on the first edge with reset=1:
  - out0..out3 = 0, valid = 0, upd = 0, upd_digit = 0, err_seg = 0, err_an = 0.
  - Synchronizer and previous-vector registers = all ones (inactive, so no spurious change is seen).
  - Stability counter = 0, age counters = 0, FSM = SETTLE.
  - Reset mid-settle aborts the pending capture; no pulse is emitted.
- Input path:
  - The 12-bit vector {an1..an4, dp, seg6..seg0} passes through a 2-flop synchronizer, giving s.
  - s_prev = s delayed by one cycle.
- Stability counter:
  - Cleared to 0 on any cycle where s != s_prev; otherwise increments, saturating at STABLE_CYCLES-1.
- FSM with two states:
  - SETTLE: when the counter equals STABLE_CYCLES-1, evaluate the frame and go to HOLD. The evaluation's registered results appear on the next cycle.
  - HOLD: no evaluation. Go to SETTLE on the first cycle with s != s_prev.
  - Net effect: one evaluation per stable frame, however long the frame lasts.
- Frame evaluation (results registered, visible one cycle after evaluation):
  - Exactly one anode low, known pattern: write the matching out register, upd = 1, upd_digit = index, that valid bit set, that age counter cleared.
  - Exactly one anode low, unknown pattern: err_seg = 1; no write; valid and age unchanged.
  - Two or more anodes low: err_an = 1; no write.
  - All anodes high (blanking): nothing happens.
- Pin-to-upd latency with the pins held steady: STABLE_CYCLES+3 clocks. All pulses last exactly one cycle.
- Decode table, {g,f,e,d,c,b,a} to code:
  - 1000000 -> 0
  - 1111001 -> 1
  - 0100100 -> 2
  - 0110000 -> 3
  - 0011001 -> 4
  - 0010010 -> 5
  - 0000010 -> 6
  - 1111000 -> 7
  - 0000000 -> 8
  - 0010000 -> 9
  - 0000110 -> A (E glyph)
  - 1111111 -> B (blank)
  - 0111111 -> C (dash)
  - Any other pattern is unknown.
- Timeout:
  - One 20-bit age counter per digit increments every cycle, saturating.
  - When it reaches TIMEOUT-1, the digit's valid bit clears on the next cycle; out keeps its last value.
  - If a capture and the timeout threshold land on the same cycle, the capture wins: valid stays 1 and age resets.
- The segment lines may glitch during anode switching. The stability filter must reject any glitch shorter than STABLE_CYCLES and capture nothing from it.

Test Plan:
- Reset, then hold an4=0 (others 1) and segs=0100100 for 40 cycles -> upd pulses once at cycle 19 after the pin change (STABLE_CYCLES+3 = 16+3), upd_digit=0, out0=2, valid=0001; no second pulse.
- Drive the full driver scan with codes 3,7,A,B on digits 0..3 at 64 cycles per digit -> out0..out3 = 3,7,A,B, valid=1111, exactly one upd per digit slot, no errors.
- Hold an2=0 with segs=1010101 for 20 cycles -> single err_seg pulse; out2 and valid[2] unchanged.
- Hold an1=0 and an3=0 together for 20 cycles -> single err_an pulse; no upd. A 10-cycle glitch on seg3 inside a stable frame -> no extra upd.
- Capture digit 1, then hold all anodes high with TIMEOUT=100 -> valid[1] drops at cycle 100 after the capture; out1 is retained. Assert reset at cycle 8 of a settle -> no pulse, all outputs zero.

Source files
------------

// File: rtl/display_scan_decoder_if.sv
// Pin bundle between a multiplexed seven-segment driver and its scan decoder.
// The master drives the active-low display lines and the slave returns the decoded digits and status pulses.
interface display_scan_decoder_if;
    logic       seg0, seg1, seg2, seg3, seg4, seg5, seg6;
    logic       dp;
    logic       an1, an2, an3, an4;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] valid;
    logic       upd;
    logic [1:0] upd_digit;
    logic       err_seg;
    logic       err_an;

    modport master (
        output seg0, seg1, seg2, seg3, seg4, seg5, seg6, dp, an1, an2, an3, an4,
        input  out0, out1, out2, out3, valid, upd, upd_digit, err_seg, err_an
    );

    modport slave (
        input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, dp, an1, an2, an3, an4,
        output out0, out1, out2, out3, valid, upd, upd_digit, err_seg, err_an
    );
endinterface

// File: rtl/display_scan_decoder.sv
// Watches a four-digit multiplexed seven-segment display, waits for each frame to settle,
// and inverse-decodes the lit digit back to its 4-bit code with per-digit staleness tracking.
module display_scan_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 524288
) (
    input  logic                   clk,
    input  logic                   reset,
    display_scan_decoder_if.slave  bus
);
    localparam int              CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [19:0]     AGE_LAST = 20'(TIMEOUT - 1);

    typedef enum logic {SETTLE, HOLD} state_e;

    // Bit 4 flags a recognised glyph, bits 3:0 carry its code.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
            7'b0000110: decode = 5'h1A;
            7'b1111111: decode = 5'h1B;
            7'b0111111: decode = 5'h1C;
            default:    decode = 5'h00;
        endcase
    endfunction

    logic [11:0]      raw;
    logic [11:0]      sync1_q, s_q, s_prev_q;
    logic [CW-1:0]    cnt_q;
    state_e           state_q;
    logic [3:0][3:0]  out_q;
    logic [3:0][19:0] age_q;
    logic [3:0]       valid_q;
    logic             upd_q, err_seg_q, err_an_q;
    logic [1:0]       upd_digit_q;

    logic       changed, eval, single, multi, capture;
    logic [3:0] an_act;
    logic [4:0] dec;
    logic [1:0] idx;

    assign raw = {bus.an1, bus.an2, bus.an3, bus.an4, bus.dp,
                  bus.seg6, bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0};

    assign changed = (s_q != s_prev_q);
    assign an_act  = ~s_q[11:8];
    assign single  = ($countones(an_act) == 1);
    assign multi   = ($countones(an_act) > 1);
    assign dec     = decode(s_q[6:0]);
    // A frame that moves on the very cycle the counter tops out is not trusted.
    assign eval    = (state_q == SETTLE) && (cnt_q == CNT_MAX) && !changed;
    assign capture = eval && single && dec[4];

    always_comb begin
        idx = '0;
        for (int i = 0; i < 4; i++)
            if (an_act[i]) idx = 2'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '1;
            s_q         <= '1;
            s_prev_q    <= '1;
            cnt_q       <= '0;
            state_q     <= SETTLE;
            out_q       <= '0;
            age_q       <= '0;
            valid_q     <= '0;
            upd_q       <= 1'b0;
            upd_digit_q <= '0;
            err_seg_q   <= 1'b0;
            err_an_q    <= 1'b0;
        end else begin
            sync1_q   <= raw;
            s_q       <= sync1_q;
            s_prev_q  <= s_q;
            upd_q     <= 1'b0;
            err_seg_q <= 1'b0;
            err_an_q  <= 1'b0;

            if (changed)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;

            case (state_q)
                SETTLE: if (eval) begin
                    state_q <= HOLD;
                    if (capture) begin
                        out_q[idx]  <= dec[3:0];
                        upd_q       <= 1'b1;
                        upd_digit_q <= idx;
                    end else if (single) begin
                        err_seg_q <= 1'b1;
                    end else if (multi) begin
                        err_an_q <= 1'b1;
                    end
                end
                HOLD: if (changed) state_q <= SETTLE;
                default: state_q <= SETTLE;
            endcase

            // Capture outranks the timeout when both land on the same cycle.
            for (int d = 0; d < 4; d++) begin
                if (capture && idx == 2'(d)) begin
                    age_q[d]   <= '0;
                    valid_q[d] <= 1'b1;
                end else begin
                    if (age_q[d] != '1) age_q[d] <= age_q[d] + 1'b1;
                    if (age_q[d] == AGE_LAST) valid_q[d] <= 1'b0;
                end
            end
        end
    end

    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.valid     = valid_q;
    assign bus.upd       = upd_q;
    assign bus.upd_digit = upd_digit_q;
    assign bus.err_seg   = err_seg_q;
    assign bus.err_an    = err_an_q;
endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: a scoreboard of expected captures and error pulses
// is filled as pins are driven and drained by a monitor watching the decoder's pulses.
module tb_display_scan_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // an_n[0] = an4 (digit 0) ... an_n[3] = an1 (digit 3); seg_n = {g..a}
    logic [3:0] an_n  = 4'hF;
    logic [6:0] seg_n = 7'h7F;
    logic       dp_n  = 1'b1;

    display_scan_decoder_if bus_a();
    display_scan_decoder_if bus_b();

    assign {bus_a.an1, bus_a.an2, bus_a.an3, bus_a.an4} = an_n;
    assign {bus_b.an1, bus_b.an2, bus_b.an3, bus_b.an4} = an_n;
    assign {bus_a.seg6, bus_a.seg5, bus_a.seg4, bus_a.seg3, bus_a.seg2, bus_a.seg1, bus_a.seg0} = seg_n;
    assign {bus_b.seg6, bus_b.seg5, bus_b.seg4, bus_b.seg3, bus_b.seg2, bus_b.seg1, bus_b.seg0} = seg_n;
    assign bus_a.dp = dp_n;
    assign bus_b.dp = dp_n;

    display_scan_decoder dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    display_scan_decoder #(.TIMEOUT(100)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct { logic [1:0] dig; logic [3:0] code; } cap_t;
    cap_t exp_q[$];
    int   err_q[$];        // 1 = err_seg, 2 = err_an
    int   checks = 0;
    int   errors = 0;
    int   upd_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] out_a(input logic [1:0] d);
        case (d)
            2'd0:    out_a = bus_a.out0;
            2'd1:    out_a = bus_a.out1;
            2'd2:    out_a = bus_a.out2;
            default: out_a = bus_a.out3;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_a.upd) begin
                upd_cnt++;
                check("upd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cap_t e;
                    e = exp_q.pop_front();
                    check("upd_digit", 32'(bus_a.upd_digit), 32'(e.dig));
                    check("upd_code", 32'(out_a(bus_a.upd_digit)), 32'(e.code));
                end
            end
            if (bus_a.err_seg)
                check("err_seg_kind", 32'd1, (err_q.size() != 0) ? 32'(err_q.pop_front()) : 32'd0);
            if (bus_a.err_an)
                check("err_an_kind", 32'd2, (err_q.size() != 0) ? 32'(err_q.pop_front()) : 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an_n  = a;
        seg_n = s;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs_a"}, {bus_a.out3, bus_a.out2, bus_a.out1, bus_a.out0}, 32'h0);
        check({tag, "_stat_a"}, {bus_a.valid, bus_a.upd, bus_a.upd_digit, bus_a.err_seg, bus_a.err_an}, 32'h0);
        check({tag, "_outs_b"}, {bus_b.out3, bus_b.out2, bus_b.out1, bus_b.out0}, 32'h0);
        check({tag, "_stat_b"}, {bus_b.valid, bus_b.upd, bus_b.upd_digit, bus_b.err_seg, bus_b.err_an}, 32'h0);
    endtask

    logic [6:0] scan_seg [4] = '{7'b0110000, 7'b1111000, 7'b0000110, 7'b1111111};
    logic [3:0] scan_code[4] = '{4'h3, 4'h7, 4'hA, 4'hB};

    initial begin
        int base, lat, k;
        bit found;

        tick(3);
        check_zero("reset");
        reset = 1'b0;

        // Single digit held steady: one capture, STABLE_CYCLES+3 clocks after the pins move.
        base = upd_cnt;
        lat  = 0;
        drive(4'b1110, 7'b0100100);
        exp_q.push_back('{2'd0, 4'h2});
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus_a.upd && lat == 0) lat = i;
        end
        check("first_latency", 32'(lat), 32'd19);
        check("first_upd_count", 32'(upd_cnt - base), 32'd1);
        check("first_out0", 32'(bus_a.out0), 32'h2);
        check("first_valid", 32'(bus_a.valid), 32'b0001);

        // Full scan, 64 cycles per digit.
        base = upd_cnt;
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back('{2'(d), scan_code[d]});
            drive(~(4'b0001 << d), scan_seg[d]);
            tick(64);
        end
        check("scan_upd_count", 32'(upd_cnt - base), 32'd4);
        check("scan_outs", {bus_a.out3, bus_a.out2, bus_a.out1, bus_a.out0}, 32'hBA73);
        check("scan_valid", 32'(bus_a.valid), 32'hF);
        check("scan_drained", 32'(exp_q.size()), 32'd0);

        // Illegal segment pattern on digit 2.
        drive(4'b1011, 7'b1010101);
        err_q.push_back(1);
        tick(24);
        check("errseg_out2", 32'(bus_a.out2), 32'hA);
        check("errseg_valid", 32'(bus_a.valid), 32'hF);
        check("errseg_drained", 32'(err_q.size()), 32'd0);

        // Two anodes low at once.
        base = upd_cnt;
        drive(4'b0101, 7'b0000000);
        err_q.push_back(2);
        tick(24);
        check("erran_no_upd", 32'(upd_cnt - base), 32'd0);
        check("erran_drained", 32'(err_q.size()), 32'd0);

        // A 10-cycle seg3 glitch never gets captured; the restored frame settles and is re-read.
        base = upd_cnt;
        drive(4'b1110, 7'b0010010);
        exp_q.push_back('{2'd0, 4'h5});
        tick(30);
        seg_n[3] = ~seg_n[3];
        tick(10);
        seg_n[3] = ~seg_n[3];
        exp_q.push_back('{2'd0, 4'h5});
        tick(30);
        check("glitch_upd_count", 32'(upd_cnt - base), 32'd2);
        check("glitch_out0", 32'(bus_a.out0), 32'h5);
        check("glitch_drained", 32'(exp_q.size()), 32'd0);

        // Timeout on the TIMEOUT=100 instance.
        drive(4'b1101, 7'b1111000);
        exp_q.push_back('{2'd1, 4'h7});
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (bus_b.upd) found = 1'b1;
        end
        check("to_capture_seen", 32'(found), 32'd1);
        check("to_valid_set", 32'(bus_b.valid[1]), 32'd1);
        drive(4'b1111, 7'b1111111);
        k = 0;
        while (bus_b.valid[1] && k < 200) begin
            tick(1);
            k++;
        end
        check("to_drop_cycle", 32'(k), 32'd100);
        check("to_out1_kept", 32'(bus_b.out1), 32'h7);
        check("to_drained", 32'(exp_q.size()), 32'd0);

        // Reset partway through a settle cancels the pending capture.
        base = upd_cnt;
        drive(4'b1110, 7'b0000010);
        tick(10);
        reset = 1'b1;
        drive(4'b1111, 7'b1111111);
        tick(2);
        check_zero("midreset");
        reset = 1'b0;
        tick(40);
        check_zero("after_reset");
        check("after_reset_no_upd", 32'(upd_cnt - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
